// File: rtl/seven_segment_pkg.sv
// Shared seven-segment constants: digit patterns (bit6..bit0 = G..A),
// the blank pattern and the reader FSM state type.
package seven_segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_PATTERNS [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    IDLE,
    SETTLE
  } state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational reverse lookup: seven-segment pattern -> hex digit.
module seg_pattern_lookup
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] digit_o,
  output logic       is_digit_o,
  output logic       is_blank_o
);

  // Scan the digit table; patterns are unique so at most one entry matches.
  always_comb begin
    digit_o    = '0;
    is_digit_o = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern_i == SEG_PATTERNS[i]) begin
        digit_o    = 4'(i);
        is_digit_o = 1'b1;
      end
    end
    is_blank_o = (pattern_i == SEG_BLANK);
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Seven-segment readback: synchronises the segment lines, debounces the
// pattern for STABLE_CYCLES cycles and reports the encoded hex digit.
// Build option SEVEN_SEGMENT_READER_ACTIVE_LOW_EN: segment lines are
// active-low (common anode); the synchronised pattern is inverted.
module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_segA,
  input  logic       i_segB,
  input  logic       i_segC,
  input  logic       i_segD,
  input  logic       i_segE,
  input  logic       i_segF,
  input  logic       i_segG,
  output logic [3:0] o_value,
  output logic       o_valid,
  output logic       o_blank,
  output logic       o_error
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);

`ifdef SEVEN_SEGMENT_READER_ACTIVE_LOW_EN
  localparam logic [6:0] SYNC_RST = '1;
`else
  localparam logic [6:0] SYNC_RST = '0;
`endif

  logic [6:0] seg_raw;
  logic [6:0] sync1_q, sync2_q;
  logic [6:0] seg_s;

  state_e           state_q, state_d;
  logic [6:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       committed_q, committed_d;
  logic [3:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             error_q, error_d;

  logic [3:0] cand_digit;
  logic       cand_is_digit;
  logic       cand_is_blank;

  assign seg_raw = {i_segG, i_segF, i_segE, i_segD, i_segC, i_segB, i_segA};

  // Two-flop synchroniser per segment line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= seg_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SEVEN_SEGMENT_READER_ACTIVE_LOW_EN
  assign seg_s = ~sync2_q;
`else
  assign seg_s = sync2_q;
`endif

  seg_pattern_lookup u_lookup (
    .pattern_i  (cand_q),
    .digit_o    (cand_digit),
    .is_digit_o (cand_is_digit),
    .is_blank_o (cand_is_blank)
  );

  // FSM state, debounce and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cand_q      <= SEG_BLANK;
      cnt_q       <= '0;
      committed_q <= SEG_BLANK;
      value_q     <= '0;
      valid_q     <= 1'b0;
      blank_q     <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      error_q     <= error_d;
    end
  end

  // Next-state: detect change, debounce candidate, commit when stable.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    blank_d     = blank_q;
    error_d     = error_q;
    unique case (state_q)
      IDLE: begin
        if (seg_s != committed_q) begin
          state_d = SETTLE;
          cand_d  = seg_s;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (seg_s != cand_q) begin
          cand_d = seg_s;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_DONE) begin
          state_d = IDLE;
          // A glitch that settled back on the old pattern commits nothing.
          if (cand_q != committed_q) begin
            committed_d = cand_q;
            valid_d     = 1'b1;
            if (cand_is_digit) begin
              value_d = cand_digit;
              blank_d = 1'b0;
              error_d = 1'b0;
            end else if (cand_is_blank) begin
              blank_d = 1'b1;
              error_d = 1'b0;
            end else begin
              blank_d = 1'b0;
              error_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_value = value_q;
  assign o_valid = valid_q;
  assign o_blank = blank_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader (STABLE_CYCLES = 4).
module tb_seven_segment_reader;

  logic       clk;
  logic       rst;
  logic [6:0] pins;
  logic [3:0] o_value;
  logic       o_valid;
  logic       o_blank;
  logic       o_error;

  int checks;
  int errors;
  int pulses;

  seven_segment_reader #(.STABLE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_segA  (pins[0]),
    .i_segB  (pins[1]),
    .i_segC  (pins[2]),
    .i_segD  (pins[3]),
    .i_segE  (pins[4]),
    .i_segF  (pins[5]),
    .i_segG  (pins[6]),
    .o_value (o_value),
    .o_valid (o_valid),
    .o_blank (o_blank),
    .o_error (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count o_valid pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_valid === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a logical pattern; the active-low build sees the complement on the pins.
  task automatic set_pins(input logic [6:0] p);
`ifdef SEVEN_SEGMENT_READER_ACTIVE_LOW_EN
    pins = ~p;
`else
    pins = p;
`endif
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    set_pins(p);
    cycles(n);
  endtask

  task automatic check_outs(input string tag, input int exp_pulses, input logic [3:0] v,
                            input logic b, input logic e);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_value"}, {28'd0, o_value}, {28'd0, v});
    check({tag, "_blank"}, {31'd0, o_blank}, {31'd0, b});
    check({tag, "_error"}, {31'd0, o_error}, {31'd0, e});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    rst    = 1'b1;
    set_pins(7'h00);
    cycles(3);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check_outs("rst", 0, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;

    // Latency: pins settle before edge 0, pulse visible only after edge 6.
    set_pins(7'h5B);
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_e%0d", e), {31'd0, o_valid}, (e == 6) ? 32'd1 : 32'd0);
    end
    check_outs("dig2", 1, 4'h2, 1'b0, 1'b0);

    // Segment A chatter restarts the debounce; only E is reported.
    pulses = 0;
    hold(7'h78, 1);
    hold(7'h79, 1);
    hold(7'h78, 1);
    hold(7'h79, 12);
    check_outs("digE", 1, 4'hE, 1'b0, 1'b0);

    pulses = 0;
    hold(7'h3F, 12);
    check_outs("dig0", 1, 4'h0, 1'b0, 1'b0);

    // Short glitch returning to the committed pattern is silent.
    pulses = 0;
    hold(7'h3E, 2);
    hold(7'h3F, 12);
    check_outs("glitch", 0, 4'h0, 1'b0, 1'b0);

    pulses = 0;
    hold(7'h4F, 12);
    check_outs("dig3", 1, 4'h3, 1'b0, 1'b0);

    pulses = 0;
    hold(7'h01, 12);
    check_outs("err", 1, 4'h3, 1'b0, 1'b1);

    pulses = 0;
    hold(7'h00, 12);
    check_outs("blank", 1, 4'h3, 1'b1, 1'b0);

    // Reset mid-debounce aborts; the held pattern is then read from blank.
    pulses = 0;
    hold(7'h06, 4);
    rst = 1'b1;
    cycles(2);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check_outs("midrst", 0, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;
    cycles(12);
    check_outs("dig1", 1, 4'h1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
